inst_mem_p: RTL and testbench

INST_MEM_P -- requirements
Module: inst_mem_p

---
 rtl/inst_mem_p.sv | 114 +++++++++++
 tb/tb_inst_mem_p.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_p.sv
// Instruction memory with a self-clearing sweep and a valid/ready registered read port.
// Optional macro INST_MEM_P_WR_BYPASS_EN forwards same-edge write data to a granted read.
module inst_mem_p #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ready,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [DATA_W-1:0] storage [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign busy     = (state_q == StClear);
  assign rd_gnt   = rd_req & ~busy & (~rd_valid_q | rd_ready);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // Sweep FSM: a clr request during a sweep is simply not looked at.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = StIdle;
          clr_ptr_d = '0;
        end
      end
      StIdle: begin
        if (clr) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
    endcase
  end

  // Single write port: the sweep owns it while busy, user writes are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (rd_gnt) begin
      rd_valid_d = 1'b1;
      rd_data_d  = storage[rd_addr];
`ifdef INST_MEM_P_WR_BYPASS_EN
      // A grant implies idle, so wr_en here is a real write this edge.
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end
`endif
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      storage[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_p.sv
// Self-checking bench for inst_mem_p: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_inst_mem_p;

  localparam int DW    = 20;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef INST_MEM_P_WR_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, wr_en, rd_req, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          rd_gnt, rd_valid, busy;
  logic [DW-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  // Reference model: word array, count of words left to clear, output register.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = DEPTH;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;

  always #5 clk = ~clk;

  inst_mem_p #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_ready(rd_ready),
    .rd_gnt  (rd_gnt),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .busy    (busy)
  );

  function automatic bit m_gnt();
    return rd_req && (m_left == 0) && (!m_valid || rd_ready);
  endfunction

  // One clock edge; the model applies the same inputs the DUT sees at that edge.
  task automatic tick();
    bit g;
    g = m_gnt();
    @(posedge clk);
    if (rst) begin
      m_left  = DEPTH;
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      if (g) begin
        m_data  = (Bypass && wr_en && (wr_addr == rd_addr)) ? wr_data : m_mem[rd_addr];
        m_valid = 1'b1;
      end else if (m_valid && rd_ready) begin
        m_valid = 1'b0;
      end
      if (m_left > 0) begin
        m_mem[DEPTH - m_left] = '0;
        m_left--;
      end else begin
        if (wr_en) m_mem[wr_addr] = wr_data;
        if (clr) m_left = DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b1; rd_addr = '0; rd_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b expected 1", busy);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++; $display("FAIL reset_rd: got valid=%b data=%h expected 0/0", rd_valid, rd_data);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      checks++;
      if (rd_gnt !== 1'b0) begin
        errors++; $display("FAIL reset_gnt_blocked: got %b expected 0 at cycle %0d", rd_gnt, n);
      end
      tick();
      #1;
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL reset_busy_cycles: got %0d expected %0d", n, DEPTH);
    end
    checks++;
    if (rd_gnt !== 1'b1) begin
      errors++; $display("FAIL reset_first_gnt: got %b expected 1", rd_gnt);
    end
    tick();
    rd_req = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 20'h00000) begin
      errors++; $display("FAIL reset_first_read: got valid=%b data=%h expected 1/00000", rd_valid, rd_data);
    end
  endtask

  task automatic test_write_read();
    rd_req = 1'b0; rd_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 20'hABCDE;
    #1;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 5'd7;
    #1;
    checks++;
    if (rd_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_rd_gnt: got %b expected 1", rd_gnt);
    end
    tick();
    rd_req = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 20'hABCDE) begin
      errors++; $display("FAIL wr_rd_data: got valid=%b data=%h expected 1/ABCDE", rd_valid, rd_data);
    end
  endtask

  task automatic test_backpressure();
    rd_req = 1'b0; rd_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 20'h00011;
    #1;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 5'd7;
    #1;
    tick();
    rd_addr = 5'd8; rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rd_gnt !== 1'b0) begin
        errors++; $display("FAIL bp_gnt_stall: got %b expected 0", rd_gnt);
      end
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 20'hABCDE) begin
        errors++; $display("FAIL bp_hold: got valid=%b data=%h expected 1/ABCDE", rd_valid, rd_data);
      end
      tick();
    end
    rd_ready = 1'b1;
    #1;
    checks++;
    if (rd_gnt !== 1'b1) begin
      errors++; $display("FAIL bp_release_gnt: got %b expected 1", rd_gnt);
    end
    tick();
    rd_req = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 20'h00011) begin
      errors++; $display("FAIL bp_second_read: got valid=%b data=%h expected 1/00011", rd_valid, rd_data);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_first;
    exp_first = Bypass ? 20'h12345 : 20'h00001;
    rd_req = 1'b0; rd_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 20'h00001;
    #1;
    tick();
    wr_data = 20'h12345; rd_req = 1'b1; rd_addr = 5'd3;
    #1;
    checks++;
    if (rd_gnt !== 1'b1) begin
      errors++; $display("FAIL same_edge_gnt: got %b expected 1", rd_gnt);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data !== exp_first) begin
      errors++; $display("FAIL same_edge_data: got %h expected %h", rd_data, exp_first);
    end
    tick();
    rd_req = 1'b0;
    #1;
    checks++;
    if (rd_data !== 20'h12345) begin
      errors++; $display("FAIL same_edge_reread: got %h expected 12345", rd_data);
    end
  endtask

  task automatic test_clr_ignored();
    int n;
    rd_req = 1'b0; wr_en = 1'b0; rd_ready = 1'b1;
    clr = 1'b1;
    #1;
    tick();
    #1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      clr = (n == 5);
      tick();
      #1;
      n++;
    end
    clr = 1'b0;
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL clr_in_sweep_ignored: got %0d busy cycles expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_clear_reset();
    int n;
    rd_req = 1'b0; rd_ready = 1'b1; wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_addr = AW'(i);
      wr_data = DW'($urandom_range(1, (1 << DW) - 1));
      #1;
      tick();
    end
    wr_en = 1'b0;
    clr = 1'b1;
    #1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL midsweep_rst_busy: got %0d expected %0d", n, DEPTH);
    end
    rd_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      #1;
      checks++;
      if (rd_gnt !== 1'b1) begin
        errors++; $display("FAIL cleared_gnt: addr %0d got %b expected 1", i, rd_gnt);
      end
      tick();
      #1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
        errors++; $display("FAIL cleared_data: addr %0d got valid=%b data=%h expected 1/0", i, rd_valid, rd_data);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      clr      = ($urandom_range(0, 39) == 0);
      wr_en    = $urandom_range(0, 1) == 1;
      wr_addr  = AW'($urandom());
      wr_data  = DW'($urandom());
      rd_req   = $urandom_range(0, 9) < 6;
      rd_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom());
      rd_ready = $urandom_range(0, 1) == 1;
      #1;
      checks++;
      if (busy !== (m_left > 0) || rd_gnt !== m_gnt()) begin
        errors++; $display("FAIL rand_ctrl: cycle %0d got busy=%b gnt=%b expected busy=%b gnt=%b",
                           c, busy, rd_gnt, (m_left > 0), m_gnt());
      end
      checks++;
      if (rd_valid !== m_valid || rd_data !== m_data) begin
        errors++; $display("FAIL rand_rd: cycle %0d got valid=%b data=%h expected valid=%b data=%h",
                           c, rd_valid, rd_data, m_valid, m_data);
      end
      tick();
    end
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_bypass();
    test_clr_ignored();
    test_clear_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
